// File: rtl/rca_share_ctrl.sv
// Nibble-serial adder shared between two requesters through one 4-bit ripple-carry chain.
// Define RCA_SHARE_B2B_EN to grant a pending request in the done cycle (back-to-back ops).

module rca_share_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign c3 = c[3];
  assign co = c[4];
endmodule

module rca_share_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic [4*NIBBLES-1:0] a0,
  input  logic [4*NIBBLES-1:0] b0,
  input  logic                 cin0,
  input  logic                 req1,
  input  logic [4*NIBBLES-1:0] a1,
  input  logic [4*NIBBLES-1:0] b1,
  input  logic                 cin1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 busy,
  output logic                 done,
  output logic                 owner,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic               ptr;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [W-1:0]       op_a, op_b;
  logic               take, win, last;
  logic [3:0]         nib_a, nib_b, add_s;
  logic               add_c3, add_co;
`ifdef RCA_SHARE_B2B_EN
  logic               pend;
  logic               pend_owner;
`endif

  rca_share_add4 u_add4 (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry),
    .s  (add_s),
    .c3 (add_c3),
    .co (add_co)
  );

  always_comb begin
    nib_a     = op_a[4*int'(idx) +: 4];
    nib_b     = op_b[4*int'(idx) +: 4];
    last      = (idx == IDX_W'(NIBBLES - 1));
    win       = (req0 & req1) ? ptr : ~req0;
    take      = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          take      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
`ifdef RCA_SHARE_B2B_EN
          // Granting on the final nibble edge lets gnt appear alongside done.
          take = req0 | req1;
`endif
        end
      end
      DONE: begin
        state_nxt = IDLE;
`ifdef RCA_SHARE_B2B_EN
        if (pend) state_nxt = RUN;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture: only meaningful once granted, so no reset.
  always_ff @(posedge clk) begin
    if (take) begin
      op_a <= win ? a1 : a0;
      op_b <= win ? b1 : b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      owner <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
`ifdef RCA_SHARE_B2B_EN
      pend       <= 1'b0;
      pend_owner <= 1'b0;
`endif
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      busy <= (state_nxt != IDLE);

      case (state)
        RUN: begin
          sum[4*int'(idx) +: 4] <= add_s;
          carry                 <= add_co;
          idx                   <= idx + 1'b1;
          if (last) begin
            cout <= add_co;
            ovf  <= add_c3 ^ add_co;
            done <= 1'b1;
            idx  <= '0;
          end
        end
`ifdef RCA_SHARE_B2B_EN
        DONE: begin
          // Result registers switch to the new op only after the done cycle.
          if (pend) begin
            owner <= pend_owner;
            sum   <= '0;
            pend  <= 1'b0;
          end
        end
`endif
        default: ;
      endcase

      if (take) begin
        carry <= win ? cin1 : cin0;
        gnt0  <= ~win;
        gnt1  <= win;
        ptr   <= ~win;
        if (state == IDLE) begin
          owner <= win;
          sum   <= '0;
          idx   <= '0;
        end
`ifdef RCA_SHARE_B2B_EN
        else begin
          pend       <= 1'b1;
          pend_owner <= win;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_rca_share_ctrl.sv
// Self-checking bench for rca_share_ctrl (NIBBLES=4, back-to-back feature off).
module tb_rca_share_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, cin0 = 1'b0, cin1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, busy, done, owner, cout, ovf;
  logic [W-1:0] sum;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit tb_ptr = 1'b0;

  rca_share_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
    .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .owner(owner), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit c);
    logic [16:0] t;
    int sa, sb, tot;
    bit v;
    t   = {1'b0, a} + {1'b0, b} + 17'(c);
    sa  = a[W-1] ? int'(a) - 65536 : int'(a);
    sb  = b[W-1] ? int'(b) - 65536 : int'(b);
    tot = sa + sb + int'(c);
    v   = (tot > 32767) || (tot < -32768);
    return {v, t};
  endfunction

  task automatic drive(input bit id, input bit on, input logic [W-1:0] a, input logic [W-1:0] b, input bit c);
    if (id) begin req1 = on; a1 = a; b1 = b; cin1 = c; end
    else    begin req0 = on; a0 = a; b0 = b; cin0 = c; end
  endtask

  task automatic scramble(input bit id);
    drive(id, 1'b0, W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 40);
  endtask

  task automatic check_result(input string tag, input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit c);
    logic [17:0] m;
    m = model(a, b, c);
    check({tag, "_sum"},   32'(sum),   32'(m[15:0]));
    check({tag, "_cout"},  32'(cout),  32'(m[16]));
    check({tag, "_ovf"},   32'(ovf),   32'(m[17]));
    check({tag, "_owner"}, 32'(owner), 32'(id));
  endtask

  task automatic run_op(input string tag, input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit c);
    int lat;
    drive(id, 1'b1, a, b, c);
    @(posedge clk); #1;
    check({tag, "_gnt"}, 32'({gnt1, gnt0}), id ? 32'h2 : 32'h1);
    check({tag, "_busy"}, 32'(busy), 32'h1);
    check({tag, "_sumclr"}, 32'(sum), 32'h0);
    tb_ptr = ~id;
    scramble(id);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'(N));
    check_result(tag, id, a, b, c);
    @(posedge clk); #1;
    check({tag, "_done1"}, 32'(done), 32'h0);
    check({tag, "_idle"}, 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_result({tag, "_hold"}, id, a, b, c);
  endtask

  initial begin : main
    int lat, last_cyc, n_g0, n_done;
    bit w, rid;
    logic [W-1:0] ra, rb;
    logic [W-1:0] edge_vals [4];

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'({gnt0, gnt1, busy, done, owner, cout, ovf, sum}), 32'h0);
    rst_n = 1'b1;

    // directed vectors
    run_op("t1234", 1'b0, 16'h1234, 16'h0FFF, 1'b0);
    run_op("tffff", 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    run_op("t7fff", 1'b0, 16'h7FFF, 16'h0001, 1'b0);
    run_op("tcin",  1'b0, 16'h0000, 16'h0000, 1'b1);

    // both requesters held: alternating grants, fixed spacing
    drive(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0);
    drive(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b1);
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (!(gnt0 | gnt1) && lat < 20);
      w = tb_ptr;
      check("alt_gnt", 32'({gnt1, gnt0}), w ? 32'h2 : 32'h1);
      if (k > 0) check("alt_gap", 32'(cyc - last_cyc), 32'd6);
      last_cyc = cyc;
      tb_ptr = ~w;
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
      wait_done(lat);
      check("alt_lat", 32'(lat), 32'(N));
      if (w) check_result("alt1", 1'b1, 16'h8000, 16'h8000, 1'b1);
      else   check_result("alt0", 1'b0, 16'h1111, 16'h2222, 1'b0);
    end
    @(posedge clk); #1;

    // reset during the second RUN cycle
    drive(1'b1, 1'b1, 16'h0F0F, 16'h00F1, 1'b1);
    @(posedge clk); #1;
    check("rst_gnt", 32'({gnt1, gnt0}), 32'h2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    tb_ptr = 1'b0;
    #1;
    check("rst_async", 32'({gnt0, gnt1, busy, done, owner, cout, ovf, sum}), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_held", 32'({gnt0, gnt1, busy, done, owner, cout, ovf, sum}), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_regnt", 32'({gnt1, gnt0}), 32'h2);
    tb_ptr = 1'b0;
    req1 = 1'b0;
    wait_done(lat);
    check("rst_lat", 32'(lat), 32'(N));
    check_result("rst_op", 1'b1, 16'h0F0F, 16'h00F1, 1'b1);
    @(posedge clk); #1;

    // req0 pulsed while busy is dropped
    drive(1'b1, 1'b1, 16'hABCD, 16'h1111, 1'b0);
    @(posedge clk); #1;
    check("pulse_gnt1", 32'({gnt1, gnt0}), 32'h2);
    tb_ptr = 1'b0;
    req1 = 1'b0;
    n_g0 = 0;
    n_done = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 1) drive(1'b0, 1'b1, 16'h5555, 16'h5555, 1'b0);
      if (i == 2) req0 = 1'b0;
      @(posedge clk); #1;
      n_g0 += int'(gnt0);
      n_done += int'(done);
    end
    check("pulse_nogrant", 32'(n_g0), 32'h0);
    check("pulse_onedone", 32'(n_done), 32'h1);
    check_result("pulse_op", 1'b1, 16'hABCD, 16'h1111, 1'b0);

    // randomized ops, sprinkled with edge operands
    edge_vals[0] = 16'h0000; edge_vals[1] = 16'hFFFF;
    edge_vals[2] = 16'h7FFF; edge_vals[3] = 16'h8000;
    for (int r = 0; r < 12; r++) begin
      rid = 1'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
      run_op("rand", rid, ra, rb, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
